// File: rtl/hevc_tr_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hevc_tr_pkg
// Purpose  : Shared types, the HEVC 32-point DCT table, the 4x4 DST-VII table
//            and small helpers for the inverse-transform coefficient sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package hevc_tr_pkg;

  typedef enum logic [1:0] {SZ4 = 2'd0, SZ8 = 2'd1, SZ16 = 2'd2, SZ32 = 2'd3} size_e;
  typedef enum logic [0:0] {IDLE = 1'b0, STREAM = 1'b1} state_e;

  typedef logic [0:31][0:31][7:0] coef32_t;
  typedef logic [0:3][0:3][7:0]   dst4_t;

  // Integer approximations of 64*sqrt(2)*cos(pi*m/64), m = 0..32.
  // Entry 0 is only ever reached by row 0, whose DC basis is a flat 64.
  localparam logic [0:32][7:0] C_MAG = {
    8'd64, 8'd90, 8'd90, 8'd90, 8'd89, 8'd88, 8'd87, 8'd85,
    8'd83, 8'd82, 8'd80, 8'd78, 8'd75, 8'd73, 8'd70, 8'd67,
    8'd64, 8'd61, 8'd57, 8'd54, 8'd50, 8'd46, 8'd43, 8'd38,
    8'd36, 8'd31, 8'd25, 8'd22, 8'd18, 8'd13, 8'd9,  8'd4,
    8'd0
  };

  localparam dst4_t DST4 = {
    8'd29,   8'd55,    8'd74,    8'd84,
    8'd74,   8'd74,    8'd0,     8'(-74),
    8'd84,   8'(-29),  8'(-74),  8'd55,
    8'd55,   8'(-84),  8'd74,    8'(-29)
  };

  // Transform size in points from the 2-bit size code.
  function automatic logic [5:0] size_to_n(input size_e s);
    return 6'd4 << s;
  endfunction

  // One entry of the 32-point table: the cosine phase (2n+1)*k is folded
  // into the first quadrant, and the sign follows the quadrant it came from.
  function automatic logic [7:0] coef32_calc(input int k, input int n);
    int m;
    m = ((2 * n + 1) * k) % 128;
    if (m > 64) m = 128 - m;
    if (k == 0) return 8'd64;
    if (m > 32) return 8'd0 - C_MAG[6'(64 - m)];
    return C_MAG[6'(m)];
  endfunction

  function automatic coef32_t build_coef32();
    coef32_t t;
    for (int k = 0; k < 32; k++) begin
      for (int n = 0; n < 32; n++) begin
        t[5'(k)][5'(n)] = coef32_calc(k, n);
      end
    end
    return t;
  endfunction

  localparam coef32_t COEF32 = build_coef32();

endpackage
`default_nettype wire

// File: rtl/hevc_tr_coeff_lut.sv
`default_nettype none
// ============================================================================
// Module   : hevc_tr_coeff_lut
// Purpose  : Combinational coefficient lookup. The row is already scaled to
//            the 32-point table by the caller; dst selects the 4x4 DST table.
// Revision : 1.0 - initial release
// ============================================================================
module hevc_tr_coeff_lut
  import hevc_tr_pkg::*;
(
  input  logic [4:0]        i_row,
  input  logic [4:0]        i_col,
  input  logic              i_dst,
  output logic signed [7:0] o_coef
);

  // Pick the DST entry when requested, otherwise the 32-point DCT entry.
  always_comb begin
    o_coef = COEF32[i_row][i_col];
    if (i_dst) o_coef = DST4[i_row[1:0]][i_col[1:0]];
  end

endmodule
`default_nettype wire

// File: rtl/hevc_tr_coeff_seq.sv
`default_nettype none
// ============================================================================
// Module   : hevc_tr_coeff_seq
// Purpose  : Streams one NxN inverse-transform matrix per request as
//            LANES-wide beats, row-major or transposed.
// Revision : 1.0 - initial release
// ============================================================================
module hevc_tr_coeff_seq
  import hevc_tr_pkg::*;
#(
  parameter int LANES  = 4,
  parameter int COEF_W = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_req_valid,
  output logic                      o_req_ready,
  input  logic [1:0]                i_req_size,
  input  logic                      i_req_dst,
  input  logic                      i_req_transpose,
  output logic                      o_out_valid,
  input  logic                      i_out_ready,
  output logic [LANES*COEF_W-1:0]   o_out_data,
  output logic                      o_out_last_row,
  output logic                      o_out_last
);

  localparam logic [5:0] c_lanes = 6'(LANES);

  state_e                    r_state, w_state_nxt;
  size_e                     r_size, w_sel_size;
  logic                      r_dst, r_tr, w_sel_dst, w_sel_tr;
  logic [4:0]                r_k, r_n, w_ak, w_an;
  logic                      r_valid, r_last_row, r_last;
  logic [LANES*COEF_W-1:0]   r_data, w_data_nxt;
  logic [5:0]                w_cur_n, w_sel_n;
  logic                      w_accept, w_fire, w_load;
  logic                      w_nxt_last_row, w_nxt_last, w_dst_eff;
  logic [1:0]                w_shift;

  assign w_accept = (r_state == IDLE) && i_req_valid;
  assign w_fire   = r_valid && i_out_ready;
  assign w_load   = w_accept || (w_fire && !r_last);
  assign w_cur_n  = size_to_n(r_size);

  // Address of the beat to load next: (0,0) of the incoming request when
  // idle, otherwise one step along the traversal from the beat on display.
  always_comb begin
    w_sel_size = r_size;
    w_sel_dst  = r_dst;
    w_sel_tr   = r_tr;
    w_ak       = r_k;
    w_an       = r_n;
    if (!r_tr) begin
      if ({1'b0, r_n} + c_lanes == w_cur_n) begin
        w_an = 5'd0;
        w_ak = r_k + 5'd1;
      end else begin
        w_an = r_n + 5'(LANES);
      end
    end else begin
      if ({1'b0, r_k} + c_lanes == w_cur_n) begin
        w_ak = 5'd0;
        w_an = r_n + 5'd1;
      end else begin
        w_ak = r_k + 5'(LANES);
      end
    end
    if (r_state == IDLE) begin
      w_sel_size = size_e'(i_req_size);
      w_sel_dst  = i_req_dst;
      w_sel_tr   = i_req_transpose;
      w_ak       = 5'd0;
      w_an       = 5'd0;
    end
  end

  assign w_sel_n        = size_to_n(w_sel_size);
  assign w_dst_eff      = w_sel_dst && (w_sel_size == SZ4);
  assign w_shift        = 2'd3 - 2'(w_sel_size);
  assign w_nxt_last_row = w_sel_tr ? ({1'b0, w_ak} + c_lanes == w_sel_n)
                                   : ({1'b0, w_an} + c_lanes == w_sel_n);
  assign w_nxt_last     = w_nxt_last_row &&
                          (w_sel_tr ? ({1'b0, w_an} == w_sel_n - 6'd1)
                                    : ({1'b0, w_ak} == w_sel_n - 6'd1));

  generate
    for (genvar i = 0; i < LANES; i++) begin : g_lane
      logic [4:0]        w_lk, w_ln, w_row;
      logic signed [7:0] w_coef;
      assign w_lk  = w_sel_tr ? w_ak + 5'(i) : w_ak;
      assign w_ln  = w_sel_tr ? w_an : w_an + 5'(i);
      assign w_row = w_dst_eff ? w_lk : (w_lk << w_shift);
      hevc_tr_coeff_lut u_lut (
        .i_row  (w_row),
        .i_col  (w_ln),
        .i_dst  (w_dst_eff),
        .o_coef (w_coef)
      );
      assign w_data_nxt[i*COEF_W +: COEF_W] = COEF_W'(w_coef);
    end
  endgenerate

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state: leave IDLE on an accepted request, return after the last beat.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = STREAM;
      STREAM:  if (w_fire && r_last) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Output beat register: load on accept or on each non-final transfer,
  // clear after the final transfer, hold under back-pressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid    <= 1'b0;
      r_data     <= '0;
      r_last_row <= 1'b0;
      r_last     <= 1'b0;
      r_k        <= 5'd0;
      r_n        <= 5'd0;
      r_size     <= SZ4;
      r_dst      <= 1'b0;
      r_tr       <= 1'b0;
    end else if (w_load) begin
      r_valid    <= 1'b1;
      r_data     <= w_data_nxt;
      r_last_row <= w_nxt_last_row;
      r_last     <= w_nxt_last;
      r_k        <= w_ak;
      r_n        <= w_an;
      r_size     <= w_sel_size;
      r_dst      <= w_sel_dst;
      r_tr       <= w_sel_tr;
    end else if (w_fire) begin
      r_valid    <= 1'b0;
      r_data     <= '0;
      r_last_row <= 1'b0;
      r_last     <= 1'b0;
    end
  end

  assign o_req_ready    = (r_state == IDLE);
  assign o_out_valid    = r_valid;
  assign o_out_data     = r_data;
  assign o_out_last_row = r_last_row;
  assign o_out_last     = r_last;

endmodule
`default_nettype wire

// File: tb/tb_hevc_tr_coeff_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_hevc_tr_coeff_seq
// Purpose  : Directed self-checking bench for hevc_tr_coeff_seq (LANES=4,
//            COEF_W=8) with hand-computed coefficient beats.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hevc_tr_coeff_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req_valid, i_req_dst, i_req_transpose, i_out_ready;
  logic [1:0]  i_req_size;
  logic        o_req_ready, o_out_valid, o_out_last_row, o_out_last;
  logic [31:0] o_out_data;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hevc_tr_coeff_seq #(.LANES(4), .COEF_W(8)) dut (
    .clk             (clk),
    .rst             (rst),
    .i_req_valid     (i_req_valid),
    .o_req_ready     (o_req_ready),
    .i_req_size      (i_req_size),
    .i_req_dst       (i_req_dst),
    .i_req_transpose (i_req_transpose),
    .o_out_valid     (o_out_valid),
    .i_out_ready     (i_out_ready),
    .o_out_data      (o_out_data),
    .o_out_last_row  (o_out_last_row),
    .o_out_last      (o_out_last)
  );

  function automatic logic [31:0] pk(input int a, input int b, input int c, input int d);
    return {8'(d), 8'(c), 8'(b), 8'(a)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic req(input int sz, input bit dst, input bit tr);
    i_req_size      = 2'(sz);
    i_req_dst       = dst;
    i_req_transpose = tr;
    i_req_valid     = 1'b1;
    @(negedge clk);
    i_req_valid     = 1'b0;
  endtask

  // Capture the beat on display at this falling edge, then step one cycle.
  task automatic get_beat(output logic [31:0] d, output logic lr, output logic l);
    int t;
    t = 0;
    while (o_out_valid !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) chk("beat_timeout", 64'(o_out_valid), 64'd1);
    d  = o_out_data;
    lr = o_out_last_row;
    l  = o_out_last;
    @(negedge clk);
  endtask

  logic [31:0] d, d_hold;
  logic        lr, l;
  logic [31:0] dct4 [4];
  logic [31:0] dst4 [4];

  initial begin
    dct4[0] = pk(64, 64, 64, 64);   dct4[1] = pk(83, 36, -36, -83);
    dct4[2] = pk(64, -64, -64, 64); dct4[3] = pk(36, -83, 83, -36);
    dst4[0] = pk(29, 55, 74, 84);   dst4[1] = pk(74, 74, 0, -74);
    dst4[2] = pk(84, -29, -74, 55); dst4[3] = pk(55, -84, 74, -29);

    // Reset, with a request presented during reset that must be ignored.
    rst = 1'b1; i_req_valid = 1'b1; i_req_size = 2'd0; i_req_dst = 1'b0;
    i_req_transpose = 1'b0; i_out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0; i_req_valid = 1'b0;
    chk("rst_valid", 64'(o_out_valid), 64'd0);
    chk("rst_data", 64'(o_out_data), 64'd0);
    chk("rst_flags", 64'({o_out_last_row, o_out_last}), 64'd0);
    chk("rst_ready", 64'(o_req_ready), 64'd1);
    @(negedge clk);
    chk("rst_req_ignored", 64'(o_out_valid), 64'd0);

    // DCT-4 row-major.
    req(0, 0, 0);
    chk("dct4_latency", 64'(o_out_valid), 64'd1);
    chk("dct4_ready_low", 64'(o_req_ready), 64'd0);
    for (int i = 0; i < 4; i++) begin
      get_beat(d, lr, l);
      chk($sformatf("dct4_data%0d", i), 64'(d), 64'(dct4[i]));
      chk($sformatf("dct4_lr%0d", i), 64'(lr), 64'd1);
      chk($sformatf("dct4_last%0d", i), 64'(l), 64'(i == 3));
    end
    chk("dct4_ready_back", 64'(o_req_ready), 64'd1);
    chk("dct4_valid_end", 64'(o_out_valid), 64'd0);

    // DST-4.
    req(0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      get_beat(d, lr, l);
      chk($sformatf("dst4_data%0d", i), 64'(d), 64'(dst4[i]));
    end
    chk("dst4_end", 64'(o_out_valid), 64'd0);

    // dst with N=8 falls back to DCT-8.
    req(1, 1, 0);
    for (int i = 0; i < 16; i++) begin
      get_beat(d, lr, l);
      if (i == 0) chk("dct8dst_b0", 64'(d), 64'(pk(64, 64, 64, 64)));
      if (i == 2) chk("dct8dst_b2", 64'(d), 64'(pk(89, 75, 50, 18)));
      if (i == 15) chk("dct8dst_last", 64'(l), 64'd1);
    end
    chk("dct8dst_end", 64'(o_out_valid), 64'd0);

    // DCT-8 transposed.
    req(1, 0, 1);
    for (int i = 0; i < 16; i++) begin
      get_beat(d, lr, l);
      if (i == 0) chk("dct8t_b0", 64'(d), 64'(pk(64, 89, 83, 75)));
      chk($sformatf("dct8t_lr%0d", i), 64'(lr), 64'(i % 2));
      chk($sformatf("dct8t_last%0d", i), 64'(l), 64'(i == 15));
    end
    chk("dct8t_end", 64'(o_out_valid), 64'd0);

    // DCT-32 row-major.
    req(3, 0, 0);
    for (int i = 0; i < 256; i++) begin
      get_beat(d, lr, l);
      if (i == 7) chk("dct32_lr7", 64'(lr), 64'd1);
      if (i == 8) chk("dct32_b8", 64'(d), 64'(pk(90, 90, 88, 85)));
      if (i == 254) chk("dct32_notlast254", 64'(l), 64'd0);
      if (i == 255) begin
        chk("dct32_b255", 64'(d), 64'(pk(31, -22, 13, -4)));
        chk("dct32_last255", 64'({lr, l}), 64'd3);
      end
    end
    chk("dct32_end", 64'(o_out_valid), 64'd0);

    // Back-pressure on DCT-8 with a second request held pending.
    req(1, 0, 0);
    i_req_valid = 1'b1; i_req_size = 2'd0;
    for (int i = 0; i < 6; i++) get_beat(d, lr, l);
    i_out_ready = 1'b0;
    d_hold = o_out_data;
    chk("bp_b6", 64'(d_hold), 64'(pk(75, -18, -89, -50)));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("bp_hold%0d", i), 64'({o_out_valid, o_out_data, o_out_last_row, o_out_last}),
          64'({1'b1, d_hold, 1'b0, 1'b0}));
      chk($sformatf("bp_ready%0d", i), 64'(o_req_ready), 64'd0);
    end
    i_out_ready = 1'b1; i_req_valid = 1'b0;
    get_beat(d, lr, l);
    chk("bp_b6_again", 64'(d), 64'(pk(75, -18, -89, -50)));
    get_beat(d, lr, l);
    chk("bp_b7", 64'(d), 64'(pk(50, 89, 18, -75)));
    chk("bp_b7_lr", 64'(lr), 64'd1);
    for (int i = 8; i < 16; i++) begin
      get_beat(d, lr, l);
      chk($sformatf("bp_last%0d", i), 64'(l), 64'(i == 15));
    end
    chk("bp_end", 64'(o_out_valid), 64'd0);

    // Reset in the middle of a DCT-16 stream.
    req(2, 0, 0);
    for (int i = 0; i < 5; i++) get_beat(d, lr, l);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_valid", 64'(o_out_valid), 64'd0);
    chk("mrst_ready", 64'(o_req_ready), 64'd1);
    chk("mrst_last", 64'(o_out_last), 64'd0);
    req(0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      get_beat(d, lr, l);
      chk($sformatf("mrst_data%0d", i), 64'(d), 64'(dct4[i]));
      if (i == 3) chk("mrst_final", 64'(l), 64'd1);
    end
    chk("mrst_end", 64'(o_out_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
